unidad_control: RTL and testbench

//  Sequencer directly upstream of unidad_procesadora: fetches 16-bit instructions from a

---
 rtl/unidad_control.sv | 122 ++++++++++++
 tb/tb_unidad_control.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/unidad_control.sv
// Two-cycle FETCH/EXEC sequencer for unidad_procesadora: fetches from a combinational ROM,
// decodes into the datapath control word and constant, and branches on latched ALU flags.
module unidad_control #(
    parameter int PC_W   = 8,
    parameter int RST_PC = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [15:0]     instr,
    input  logic [3:0]      flags,
    output logic [PC_W-1:0] pc,
    output logic [15:0]     control,
    output logic [3:0]      constant_out,
    output logic            busy,
    output logic            halted
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    localparam logic [3:0] OP_ALURR = 4'h1;
    localparam logic [3:0] OP_ALURI = 4'h2;
    localparam logic [3:0] OP_SHF   = 4'h3;
    localparam logic [3:0] OP_LOAD  = 4'h4;
    localparam logic [3:0] OP_OUT   = 4'h5;
    localparam logic [3:0] OP_JMP   = 4'h6;
    localparam logic [3:0] OP_BRF   = 4'h7;
    localparam logic [3:0] OP_HALT  = 4'hF;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [15:0]     ir_q, ir_d;
    logic [3:0]      flags_q, flags_d;

    logic [3:0]      op;
    logic [1:0]      fd, fa, fb;
    logic [PC_W-1:0] pc_inc, target;

    assign op     = ir_q[15:12];
    assign fd     = ir_q[11:10];
    assign fa     = ir_q[9:8];
    assign fb     = ir_q[7:6];
    assign pc_inc = pc_q + PC_W'(1);
    assign target = PC_W'(ir_q[7:0]);

    // control layout: {A,B,dest,we,MB,alu[3:0],shf[1:0],MF,MD}
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ir_d         = ir_q;
        flags_d      = flags_q;
        control      = 16'h0000;
        constant_out = 4'h0;
        case (state_q)
            S_IDLE, S_HALT: begin
                if (start) begin
                    state_d = S_FETCH;
                    pc_d    = PC_W'(RST_PC);
                    flags_d = 4'h0;
                end
            end
            S_FETCH: begin
                ir_d    = instr;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d = S_FETCH;
                pc_d    = pc_inc;
                case (op)
                    OP_ALURR: begin
                        control = {fa, fb, fd, 1'b1, 1'b0, ir_q[5:2], 2'b00, 1'b0, 1'b0};
                        flags_d = flags;
                    end
                    OP_ALURI: begin
                        control      = {fa, 2'b00, fd, 1'b1, 1'b1, ir_q[3:0], 2'b00, 1'b0, 1'b0};
                        constant_out = ir_q[7:4];
                        flags_d      = flags;
                    end
                    OP_SHF:  control = {2'b00, fb, fd, 1'b1, 1'b0, 4'h0, ir_q[1:0], 1'b1, 1'b0};
                    OP_LOAD: control = {4'h0, fd, 1'b1, 1'b0, 4'h0, 2'b00, 1'b0, 1'b1};
                    OP_OUT:  control = {fa, fa, 2'b00, 1'b0, 1'b0, 4'b0001, 2'b00, 1'b0, 1'b0};
                    OP_JMP:  pc_d = target;
                    OP_BRF: begin
                        // cond index 0..3 selects C,Z,N,V from {V,N,Z,C}
                        if (flags_q[fd]) pc_d = target;
                    end
                    OP_HALT: begin
                        state_d = S_HALT;
                        pc_d    = pc_q;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    // Async reset drops state to IDLE, which zeroes control in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= PC_W'(RST_PC);
            ir_q    <= 16'h0000;
            flags_q <= 4'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            flags_q <= flags_d;
        end
    end

    assign pc     = pc_q;
    assign busy   = (state_q == S_FETCH) || (state_q == S_EXEC);
    assign halted = (state_q == S_HALT);

endmodule

// File: tb/tb_unidad_control.sv
// Scoreboard bench for unidad_control: directed programs in a behavioural ROM, expected
// EXEC-cycle {pc, control, constant} pushed up front and checked by an independent monitor.
module tb_unidad_control;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] instr;
    logic [3:0]  flags;
    logic [7:0]  pc;
    logic [15:0] control;
    logic [3:0]  constant_out;
    logic        busy;
    logic        halted;

    logic [15:0] rom      [256];
    logic [3:0]  flag_rom [256];

    typedef struct {
        logic [7:0]  pc;
        logic [15:0] ctrl;
        logic [3:0]  cst;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    bit   in_exec;
    int   checks;
    int   errors;

    unidad_control #(.PC_W(8), .RST_PC(0)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .instr        (instr),
        .flags        (flags),
        .pc           (pc),
        .control      (control),
        .constant_out (constant_out),
        .busy         (busy),
        .halted       (halted)
    );

    assign instr = rom[pc];
    assign flags = flag_rom[pc];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic push(input logic [7:0] p, input logic [15:0] c, input logic [3:0] k);
        exp_t e;
        e.pc   = p;
        e.ctrl = c;
        e.cst  = k;
        sb.push_back(e);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) begin
            rom[i]      = 16'h0000;
            flag_rom[i] = 4'h0;
        end
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_halt(input string nm);
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #1;
            if (halted) break;
        end
        chk(nm, {31'd0, halted}, 32'd1);
    endtask

    // Monitor: busy cycles alternate FETCH/EXEC; every EXEC must match the next expectation.
    always @(negedge clk) begin
        if (!rst_n || !busy) begin
            in_exec = 1'b0;
        end else if (!in_exec) begin
            chk("fetch_control", {16'd0, control}, 32'd0);
            chk("fetch_constant", {28'd0, constant_out}, 32'd0);
            in_exec = 1'b1;
        end else begin
            in_exec = 1'b0;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_exec: pc %0h control %0h with no expectation", pc, control);
            end else begin
                mon_e = sb.pop_front();
                chk("exec_pc", {24'd0, pc}, {24'd0, mon_e.pc});
                chk("exec_control", {16'd0, control}, {16'd0, mon_e.ctrl});
                chk("exec_constant", {28'd0, constant_out}, {28'd0, mon_e.cst});
            end
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        clear_mem();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_pc", {24'd0, pc}, 32'd0);
        chk("reset_control", {16'd0, control}, 32'd0);
        chk("reset_constant", {28'd0, constant_out}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_halted", {31'd0, halted}, 32'd0);
        rst_n = 1'b1;

        // Program 1: decode of every op class, BRF on Z/C/V/N, SHF leaving flags alone
        rom[8'h00] = 16'h4400;  flag_rom[8'h00] = 4'b0010;
        rom[8'h01] = 16'h1954;  flag_rom[8'h01] = 4'b0010;
        rom[8'h02] = 16'h7420;
        rom[8'h20] = 16'h1E08;  flag_rom[8'h20] = 4'b0001;
        rom[8'h21] = 16'h7440;
        rom[8'h22] = 16'h34C2;
        rom[8'h23] = 16'h7030;
        rom[8'h30] = 16'h2BA7;  flag_rom[8'h30] = 4'b1000;
        rom[8'h31] = 16'h5200;
        rom[8'h32] = 16'h7C50;
        rom[8'h50] = 16'h7860;
        rom[8'h51] = 16'h9ABC;
        rom[8'h52] = 16'hF000;
        push(8'h00, 16'h0601, 4'h0);
        push(8'h01, 16'h5A50, 4'h0);
        push(8'h02, 16'h0000, 4'h0);
        push(8'h20, 16'h8E20, 4'h0);
        push(8'h21, 16'h0000, 4'h0);
        push(8'h22, 16'h360A, 4'h0);
        push(8'h23, 16'h0000, 4'h0);
        push(8'h30, 16'hCB70, 4'hA);
        push(8'h31, 16'hA010, 4'h0);
        push(8'h32, 16'h0000, 4'h0);
        push(8'h50, 16'h0000, 4'h0);
        push(8'h51, 16'h0000, 4'h0);
        push(8'h52, 16'h0000, 4'h0);
        pulse_start();
        wait_halt("p1_halt");
        chk("p1_halt_busy", {31'd0, busy}, 32'd0);
        chk("p1_halt_pc", {24'd0, pc}, 32'h52);
        chk("p1_halt_control", {16'd0, control}, 32'd0);
        repeat (3) @(posedge clk);
        #1 chk("p1_halt_pc_hold", {24'd0, pc}, 32'h52);

        // Program 2: flags cleared on restart, wrap FF->00, JMP 7F, HALT at 3, start while busy
        clear_mem();
        rom[8'h00] = 16'h7C05;
        rom[8'h01] = 16'h2039;  flag_rom[8'h01] = 4'b1000;
        rom[8'h02] = 16'h60FE;
        rom[8'hFE] = 16'h4C00;
        rom[8'hFF] = 16'h0000;
        rom[8'h05] = 16'h607F;
        rom[8'h7F] = 16'h5100;
        rom[8'h80] = 16'h6003;
        rom[8'h03] = 16'hF000;
        push(8'h00, 16'h0000, 4'h0);
        push(8'h01, 16'h0390, 4'h3);
        push(8'h02, 16'h0000, 4'h0);
        push(8'hFE, 16'h0E01, 4'h0);
        push(8'hFF, 16'h0000, 4'h0);
        push(8'h00, 16'h0000, 4'h0);
        push(8'h05, 16'h0000, 4'h0);
        push(8'h7F, 16'h5010, 4'h0);
        push(8'h80, 16'h0000, 4'h0);
        push(8'h03, 16'h0000, 4'h0);
        pulse_start();
        #1 chk("p2_restart_halted", {31'd0, halted}, 32'd0);
        repeat (3) @(posedge clk);
        pulse_start();
        wait_halt("p2_halt");
        chk("p2_halt_busy", {31'd0, busy}, 32'd0);
        chk("p2_halt_pc", {24'd0, pc}, 32'h03);
        chk("p2_halt_control", {16'd0, control}, 32'd0);

        // Program 3: reset asserted in the middle of an ALURR EXEC at pc 2
        clear_mem();
        rom[8'h02] = 16'h1954;
        push(8'h00, 16'h0000, 4'h0);
        push(8'h01, 16'h0000, 4'h0);
        pulse_start();
        repeat (5) @(posedge clk);
        #1;
        chk("p3_exec_pc", {24'd0, pc}, 32'h02);
        chk("p3_exec_control", {16'd0, control}, 32'h5A50);
        #1 rst_n = 1'b0;
        #1;
        chk("p3_rst_control", {16'd0, control}, 32'd0);
        chk("p3_rst_pc", {24'd0, pc}, 32'd0);
        chk("p3_rst_busy", {31'd0, busy}, 32'd0);
        chk("p3_rst_halted", {31'd0, halted}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("p3_idle_busy", {31'd0, busy}, 32'd0);
        chk("p3_idle_pc", {24'd0, pc}, 32'd0);
        chk("p3_idle_control", {16'd0, control}, 32'd0);

        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
